display_scheduler: RTL and testbench



---
 rtl/display_scheduler_pkg.sv | 9 +
 rtl/display_scheduler_rr_pick4.sv | 18 +
 rtl/display_scheduler.sv | 94 +++++++++
 tb/tb_display_scheduler.sv | 111 +++++++++++
 4 files changed

// File: rtl/display_scheduler_pkg.sv
// display_scheduler_pkg: shared state encoding, sizes and helpers for the display scheduler
package display_scheduler_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, GAP = 2'd2} state_t;
  localparam int NREQ = 4;
  localparam int CLK_DIV_100MHZ = 100000;
  function automatic logic [NREQ-1:0] onehot(input logic [1:0] i);
    return NREQ'(1) << i;
  endfunction
endpackage

// File: rtl/display_scheduler_rr_pick4.sv
// rr_pick4: round-robin pick of the first set req bit after last, wrapping back to last
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] pick,
  output logic       any
);
  logic [1:0] base;
  logic [7:0] dbl;
  logic [3:0] rot;
  always_comb begin
    base = last + 2'd1;
    dbl  = {req, req} >> base;
    rot  = dbl[3:0];
    pick = base + (rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3);
    any  = |req;
  end
endmodule

// File: rtl/display_scheduler.sv
// display_scheduler: round-robin time-sharing of a 16-bit display word between four requesters
module display_scheduler
  import display_scheduler_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_100MHZ,
  parameter int HOLD_TICKS = 1000,
  parameter int GAP_TICKS  = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [16*NREQ-1:0] data_in,
  output logic [NREQ-1:0]    ack,
  output logic [15:0]        disp_data,
  output logic               disp_blank,
  output logic [1:0]         owner,
  output logic               busy
);
  localparam int MAXT = HOLD_TICKS > GAP_TICKS ? HOLD_TICKS : GAP_TICKS;
  localparam int DW = MAXT > 1 ? $clog2(MAXT) : 1;
  localparam int PW = $clog2(CLK_DIV);
  state_t          state_q, state_d;
  logic [15:0]     disp_data_q, disp_data_d;
  logic [1:0]      owner_q, owner_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [1:0]      pick;
  logic            any, tick, hold_end, gap_end;
  rr_pick4 u_pick (
    .req  (req),
    .last (owner_q),
    .pick (pick),
    .any  (any)
  );
  always_comb begin
    tick        = presc_q == PW'(CLK_DIV - 1);
    hold_end    = tick && dwell_q == DW'(HOLD_TICKS - 1);
    gap_end     = tick && dwell_q == DW'(GAP_TICKS - 1);
    state_d     = state_q;
    disp_data_d = disp_data_q;
    owner_d     = owner_q;
    ack_d       = '0;
    presc_d     = (state_q == IDLE || tick) ? '0 : presc_q + 1'b1;
    dwell_d     = state_q == IDLE ? '0 : tick ? dwell_q + 1'b1 : dwell_q;
    case (state_q)
      IDLE: state_d = any ? SHOW : IDLE;
      SHOW: begin
        if (req[owner_q]) begin
          disp_data_d = data_in[{owner_q, 4'd0} +: 16];
          ack_d       = onehot(owner_q);
        end
        if (hold_end) begin
          dwell_d = '0;
          state_d = |(req & ~onehot(owner_q)) ? GAP : SHOW;
        end
      end
      GAP: if (gap_end) begin
        dwell_d = '0;
        state_d = any ? SHOW : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == SHOW && state_q != SHOW) begin
      owner_d     = pick;
      disp_data_d = data_in[{pick, 4'd0} +: 16];
      ack_d       = onehot(pick);
      presc_d     = '0;
      dwell_d     = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      disp_data_q <= '0;
      owner_q     <= 2'd3;
      ack_q       <= '0;
      presc_q     <= '0;
      dwell_q     <= '0;
    end else begin
      state_q     <= state_d;
      disp_data_q <= disp_data_d;
      owner_q     <= owner_d;
      ack_q       <= ack_d;
      presc_q     <= presc_d;
      dwell_q     <= dwell_d;
    end
  end
  assign ack        = ack_q;
  assign disp_data  = disp_data_q;
  assign disp_blank = state_q != SHOW;
  assign owner      = owner_q;
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed vector and sequence checks of display_scheduler
module tb_display_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [63:0] data_in = '0;
  logic [3:0]  ack;
  logic [15:0] disp_data;
  logic        disp_blank;
  logic [1:0]  owner;
  logic        busy;
  int          checks = 0;
  int          fails = 0;
  always #5 clk = ~clk;
  display_scheduler #(.CLK_DIV(4), .HOLD_TICKS(3), .GAP_TICKS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .data_in    (data_in),
    .ack        (ack),
    .disp_data  (disp_data),
    .disp_blank (disp_blank),
    .owner      (owner),
    .busy       (busy)
  );
  typedef struct {
    logic        r;
    logic [3:0]  rq;
    logic [63:0] d;
    int          n;
    logic [3:0]  ea;
    logic [15:0] ed;
    logic        eb;
    logic [1:0]  eo;
    logic        ez;
  } vec_t;
  vec_t tbl[$];
  task automatic add(input logic r, input logic [3:0] rq, input logic [63:0] d, input int n,
                     input logic [3:0] ea, input logic [15:0] ed, input logic eb,
                     input logic [1:0] eo, input logic ez);
    vec_t v;
    v = '{r, rq, d, n, ea, ed, eb, eo, ez};
    tbl.push_back(v);
  endtask
  task automatic step(input logic r, input logic [3:0] rq, input logic [63:0] d,
                      input logic [3:0] ea, input logic [15:0] ed, input logic eb,
                      input logic [1:0] eo, input logic ez, input string nm);
    rst = r;
    req = rq;
    data_in = d;
    @(posedge clk);
    #1;
    checks++;
    if ({ack, disp_data, disp_blank, owner, busy} !== {ea, ed, eb, eo, ez}) begin
      fails++;
      $display("FAIL %s: got ack=%b data=%h blank=%b owner=%0d busy=%b, want ack=%b data=%h blank=%b owner=%0d busy=%b",
               nm, ack, disp_data, disp_blank, owner, busy, ea, ed, eb, eo, ez);
    end
  endtask
  localparam logic [63:0] S1 = 64'h0000_0000_0000_1234;
  localparam logic [63:0] C2 = 64'h0000_CCCC_0000_AAAA;
  localparam logic [63:0] R1 = 64'h0000_0000_5555_0A0A;
  localparam logic [63:0] R2 = 64'h0000_0000_00FF_0A0A;
  localparam logic [63:0] X3 = 64'h3333_0000_0000_BEEF;
  localparam logic [63:0] W4 = 64'h4444_3333_2222_1111;
  initial begin
    add(1, 4'h0, 64'h0, 2, 4'h0, 16'h0000, 1, 2'd3, 0);
    add(0, 4'h0, 64'h0, 2, 4'h0, 16'h0000, 1, 2'd3, 0);
    add(0, 4'h1, S1,   45, 4'h1, 16'h1234, 0, 2'd0, 1);
    add(1, 4'h0, S1,    1, 4'h0, 16'h0000, 1, 2'd3, 0);
    add(0, 4'h5, C2,   12, 4'h1, 16'hAAAA, 0, 2'd0, 1);
    add(0, 4'h5, C2,    1, 4'h1, 16'hAAAA, 1, 2'd0, 1);
    add(0, 4'h5, C2,    7, 4'h0, 16'hAAAA, 1, 2'd0, 1);
    add(0, 4'h5, C2,   12, 4'h4, 16'hCCCC, 0, 2'd2, 1);
    add(0, 4'h5, C2,    1, 4'h4, 16'hCCCC, 1, 2'd2, 1);
    add(0, 4'h5, C2,    7, 4'h0, 16'hCCCC, 1, 2'd2, 1);
    add(0, 4'h5, C2,    2, 4'h1, 16'hAAAA, 0, 2'd0, 1);
    add(1, 4'h0, C2,    1, 4'h0, 16'h0000, 1, 2'd3, 0);
    add(0, 4'h2, R1,    1, 4'h2, 16'h5555, 0, 2'd1, 1);
    add(0, 4'h1, R1,    4, 4'h0, 16'h5555, 0, 2'd1, 1);
    add(0, 4'h3, R2,    1, 4'h2, 16'h00FF, 0, 2'd1, 1);
    add(0, 4'h1, R2,    6, 4'h0, 16'h00FF, 0, 2'd1, 1);
    add(0, 4'h1, R2,    8, 4'h0, 16'h00FF, 1, 2'd1, 1);
    add(0, 4'h1, R2,    1, 4'h1, 16'h0A0A, 0, 2'd0, 1);
    add(0, 4'h0, R2,   11, 4'h0, 16'h0A0A, 0, 2'd0, 1);
    add(0, 4'h2, R2,    1, 4'h0, 16'h0A0A, 1, 2'd0, 1);
    add(0, 4'h0, R2,    7, 4'h0, 16'h0A0A, 1, 2'd0, 1);
    add(0, 4'h0, R2,    3, 4'h0, 16'h0A0A, 1, 2'd0, 0);
    add(0, 4'h1, X3,    4, 4'h1, 16'hBEEF, 0, 2'd0, 1);
    add(1, 4'h8, X3,    1, 4'h0, 16'h0000, 1, 2'd3, 0);
    add(0, 4'h8, X3,    2, 4'h8, 16'h3333, 0, 2'd3, 1);
    foreach (tbl[i])
      for (int k = 0; k < tbl[i].n; k++)
        step(tbl[i].r, tbl[i].rq, tbl[i].d, tbl[i].ea, tbl[i].ed, tbl[i].eb, tbl[i].eo, tbl[i].ez,
             $sformatf("vec%0d.%0d", i, k));
    step(1, 4'h0, W4, 4'h0, 16'h0000, 1, 2'd3, 0, "rot_reset");
    for (int g = 0; g < 5; g++) begin
      logic [1:0]  o;
      logic [15:0] w;
      o = 2'(g % 4);
      w = W4[16*o +: 16];
      for (int k = 0; k < 12; k++)
        step(0, 4'hF, W4, 4'(1 << o), w, 0, o, 1, $sformatf("rot%0d_show%0d", g, k));
      step(0, 4'hF, W4, 4'(1 << o), w, 1, o, 1, $sformatf("rot%0d_gap0", g));
      for (int k = 1; k < 8; k++)
        step(0, 4'hF, W4, 4'h0, w, 1, o, 1, $sformatf("rot%0d_gap%0d", g, k));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
